mux_stim_checker: RTL and testbench

Self-checking stimulus stage for the select-mux datapath z = (a & ~c) | (c & b), i.e. z = c ? b : a. It sits directly upstream and downstream of that datapath. It drives a, b and c, waits for the datapath to settle, samples z, and compares it against the expected value. One start request runs all 8 input vectors and reports pass/fail plus a mismatch count.

---
 rtl/mux_stim_checker.sv | 175 +++++++++++++++++
 tb/tb_mux_stim_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stim_checker.sv
// mux_stim_checker: drives all 8 {a,b,c} vectors into the select-mux datapath
// z = c ? b : a, holds each for SETTLE_CYCLES cycles, samples z and counts
// mismatches. One accepted start runs the full sweep and reports pass/err_count.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, sampled only in IDLE
//   a, b, c           registered stimulus = vec_idx[2], vec_idx[1], vec_idx[0]
//   z                 datapath result
//   busy              high from the cycle after start acceptance until DONE is left
//   done              one-cycle pulse at end of run
//   pass              last run had zero mismatches
//   err_count         saturating mismatch count of the last run
//   vec_idx           index of the vector currently driven
//   first_fail_valid, first_fail_idx
//                     first mismatching vector of the run; only present when
//                     MUX_CHK_FIRST_FAIL_EN is defined
//
// Optional feature macro: MUX_CHK_FIRST_FAIL_EN

module mux_stim_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 z,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef MUX_CHK_FIRST_FAIL_EN
    output logic                 first_fail_valid,
    output logic [2:0]           first_fail_idx,
`endif
    output logic [2:0]           vec_idx
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};
    localparam logic [2:0]           IDX_LAST   = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_d;
    logic [ERR_CNT_W-1:0] err_d;
    logic                 busy_d, done_d, pass_d;
    logic                 mismatch_c;
`ifdef MUX_CHK_FIRST_FAIL_EN
    logic                 ff_valid_d;
    logic [2:0]           ff_idx_d;
`endif

    // Expected value is formed from the registered stimulus actually driven.
    assign mismatch_c = z != (c ? b : a);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef MUX_CHK_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_idx   <= idx_d;
            a         <= idx_d[2];
            b         <= idx_d[1];
            c         <= idx_d[0];
            err_count <= err_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
`ifdef MUX_CHK_FIRST_FAIL_EN
            first_fail_valid <= ff_valid_d;
            first_fail_idx   <= ff_idx_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = vec_idx;
        err_d   = err_count;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
`ifdef MUX_CHK_FIRST_FAIL_EN
        ff_valid_d = first_fail_valid;
        ff_idx_d   = first_fail_idx;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = SETTLE;
`ifdef MUX_CHK_FIRST_FAIL_EN
                    ff_valid_d = 1'b0;
                    ff_idx_d   = '0;
`endif
                end
            end

            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (mismatch_c && (err_count != ERR_MAX)) begin
                    err_d = err_count + ERR_CNT_W'(1);
                end
`ifdef MUX_CHK_FIRST_FAIL_EN
                if (mismatch_c && !first_fail_valid) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = vec_idx;
                end
`endif
                if (vec_idx != IDX_LAST) begin
                    idx_d   = vec_idx + 3'(1);
                    cnt_d   = CNT_RELOAD;
                    state_d = SETTLE;
                end else begin
                    // Final verdict includes the mismatch found on this edge.
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_stim_checker.sv
// Directed bench for mux_stim_checker: correct, stuck-at-0, stuck-at-1 and
// inverted datapath models, mid-run reset, and ignored/held start requests.
// A second instance with a 2-bit error counter exercises saturation.

module tb_mux_stim_checker;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned PER    = SETTLE + 1;
    localparam int unsigned N_END  = 8 * PER;
    localparam int unsigned BOUND  = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic [1:0] mode;

    logic       a, b, c, z, busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] vec_idx;

    logic       a2, b2, c2, z2, busy2, done2, pass2;
    logic [1:0] err_count2;
    logic [2:0] vec_idx2;

`ifdef MUX_CHK_FIRST_FAIL_EN
    logic       ff_valid, ff_valid2;
    logic [2:0] ff_idx, ff_idx2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Datapath models: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    always_comb begin
        case (mode)
            2'd0:    z = c ? b : a;
            2'd1:    z = 1'b0;
            2'd2:    z = 1'b1;
            default: z = ~(c ? b : a);
        endcase
    end

    assign z2 = ~(c2 ? b2 : a2);

    mux_stim_checker #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .z         (z),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
`ifdef MUX_CHK_FIRST_FAIL_EN
        .first_fail_valid (ff_valid),
        .first_fail_idx   (ff_idx),
`endif
        .vec_idx   (vec_idx)
    );

    mux_stim_checker #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .a         (a2),
        .b         (b2),
        .c         (c2),
        .z         (z2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err_count2),
`ifdef MUX_CHK_FIRST_FAIL_EN
        .first_fail_valid (ff_valid2),
        .first_fail_idx   (ff_idx2),
`endif
        .vec_idx   (vec_idx2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for done on the main instance; returns edges waited (BOUND on timeout).
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check_eq({tag, "_done_seen"}, int'(done), 1);
    endtask

    // One full run; exp_ff < 0 means no first failure expected.
    task automatic run_check(input string tag, input logic [1:0] m, input int exp_err,
                             input int exp_pass, input int exp_ff, input bit poke);
        int n;
        bit seen;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, "_busy_start"}, int'(busy), 1);
        check_eq({tag, "_idx_start"}, int'(vec_idx), 0);
        check_eq({tag, "_pass_clr"}, int'(pass), 0);
        check_eq({tag, "_err_clr"}, int'(err_count), 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < BOUND) begin
            if (poke && n == 7) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) begin
                seen = 1'b1;
            end else if (n < N_END) begin
                check_eq({tag, "_idx_step"}, int'(vec_idx), n / PER);
                check_eq({tag, "_abc_step"}, int'({a, b, c}), n / PER);
            end
        end
        check_eq({tag, "_done_seen"}, int'(seen), 1);
        check_eq({tag, "_done_edge"}, n, N_END);
        check_eq({tag, "_idx_end"}, int'(vec_idx), 7);
        check_eq({tag, "_abc_end"}, int'({a, b, c}), 7);
        check_eq({tag, "_err"}, int'(err_count), exp_err);
        check_eq({tag, "_pass"}, int'(pass), exp_pass);
        check_eq({tag, "_busy_done"}, int'(busy), 1);
`ifdef MUX_CHK_FIRST_FAIL_EN
        check_eq({tag, "_ff_valid"}, int'(ff_valid), (exp_ff >= 0) ? 1 : 0);
        if (exp_ff >= 0) check_eq({tag, "_ff_idx"}, int'(ff_idx), exp_ff);
`else
        if (exp_ff > 7) check_eq({tag, "_ff_arg"}, exp_ff, 0);
`endif
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, "_done_fall"}, int'(done), 0);
        check_eq({tag, "_busy_fall"}, int'(busy), 0);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq({tag, "_idle_busy"}, int'(busy), 0);
            check_eq({tag, "_idle_done"}, int'(done), 0);
            check_eq({tag, "_pass_hold"}, int'(pass), exp_pass);
        end
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_abc", int'({a, b, c}), 0);
        check_eq("rst_idx", int'(vec_idx), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_pass", int'(pass), 0);
        check_eq("rst_err", int'(err_count), 0);
`ifdef MUX_CHK_FIRST_FAIL_EN
        check_eq("rst_ff_valid", int'(ff_valid), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_check("t1_good", 2'd0, 0, 1, -1, 1'b0);
        run_check("t2_stuck0", 2'd1, 4, 0, 3, 1'b0);
        run_check("t3_stuck1", 2'd2, 4, 0, 0, 1'b0);

        // Saturation on the 2-bit counter instance with an inverted datapath.
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (done2) break;
        end
        check_eq("t4_done_seen", int'(done2), 1);
        check_eq("t4_done_edge", n, N_END);
        check_eq("t4_err_sat", int'(err_count2), 3);
        check_eq("t4_pass", int'(pass2), 0);
`ifdef MUX_CHK_FIRST_FAIL_EN
        check_eq("t4_ff_idx", int'(ff_idx2), 0);
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run at vec_idx 4.
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("t5_idx_pre", int'(vec_idx), 4);
        check_eq("t5_busy_pre", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_abc", int'({a, b, c}), 0);
        check_eq("t5_rst_idx", int'(vec_idx), 0);
        check_eq("t5_rst_busy", int'(busy), 0);
        check_eq("t5_rst_err", int'(err_count), 0);
        check_eq("t5_rst_pass", int'(pass), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_check("t5_after", 2'd0, 0, 1, -1, 1'b0);

        // Starts during the run and during DONE are ignored.
        run_check("t6_poke", 2'd0, 0, 1, -1, 1'b1);

        // start held high: re-accepted on the first IDLE edge, pass cleared.
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6h_busy", int'(busy), 1);
        check_eq("t6h_pass_clr", int'(pass), 0);
        wait_done("t6h_run1", n);
        check_eq("t6h_done_edge", n, N_END);
        check_eq("t6h_pass1", int'(pass), 1);
        @(posedge clk);
        #1;
        check_eq("t6h_idle_busy", int'(busy), 0);
        check_eq("t6h_idle_pass", int'(pass), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("t6h_rerun_busy", int'(busy), 1);
        check_eq("t6h_rerun_pass", int'(pass), 0);
        check_eq("t6h_rerun_idx", int'(vec_idx), 0);
        wait_done("t6h_run2", n);
        check_eq("t6h_run2_edge", n, N_END);
        check_eq("t6h_run2_pass", int'(pass), 1);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
